// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned BUF_DEPTH          = 3;

  typedef logic [1:0] buf_ptr_t;
  typedef logic [1:0] buf_cnt_t;

  // Modulo-3 pointer increment; depth is not a power of two so wrap is explicit.
  function automatic buf_ptr_t ptr_inc(input buf_ptr_t p);
    return (p == buf_ptr_t'(BUF_DEPTH - 1)) ? buf_ptr_t'(0) : p + buf_ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream of the read adapter.
interface fifo_rd_stream_if #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH
);
  import fifo_pkg::*;

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  buf_cnt_t              buf_level;

  modport master (
    input  fifo_empty, fifo_data, flush, m_ready,
    output fifo_rd_en, m_valid, m_data, buf_level
  );

  modport slave (
    output fifo_empty, fifo_data, flush, m_ready,
    input  fifo_rd_en, m_valid, m_data, buf_level
  );

endinterface

// File: rtl/fifo_rd_stream_buf.sv
// Three-entry prefetch register file with modulo-3 pointers and occupancy count.
module fifo_rd_stream_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output buf_cnt_t              occ_o
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  buf_ptr_t              wr_ptr_q, wr_ptr_d;
  buf_ptr_t              rd_ptr_q, rd_ptr_d;
  buf_cnt_t              occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      occ_d = occ_q + buf_cnt_t'(1);
      else if (!push_i && pop_i) occ_d = occ_q - buf_cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: issues FIFO reads, absorbs the 1-cycle read latency and
// presents the words as a valid/ready stream with synchronous flush.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input logic              clk,
  input logic              rst,
  fifo_rd_stream_if.master bus
);

  localparam int unsigned SUM_W = 3;

  logic                  inflight_q, inflight_d;
  logic                  rd_en_c, push_c, pop_c, valid_c;
  buf_cnt_t              occ;
  logic [DATA_WIDTH-1:0] head;

  // Issue depends only on registered state and fifo_empty, never on m_ready.
  always_comb begin
    rd_en_c    = !rst && !bus.flush && !bus.fifo_empty &&
                 ((SUM_W'(occ) + SUM_W'(inflight_q)) < SUM_W'(BUF_DEPTH));
    valid_c    = (occ != buf_cnt_t'(0)) && !bus.flush;
    pop_c      = valid_c && bus.m_ready;
    push_c     = inflight_q && !bus.flush;
    inflight_d = rd_en_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight_q <= 1'b0;
    else     inflight_q <= inflight_d;
  end

  fifo_rd_stream_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .clear_i (bus.flush),
    .wdata_i (bus.fifo_data),
    .rdata_o (head),
    .occ_o   (occ)
  );

  assign bus.fifo_rd_en = rd_en_c;
  assign bus.m_valid    = valid_c;
  assign bus.m_data     = head;
  assign bus.buf_level  = occ;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (occ != buf_cnt_t'(BUF_DEPTH)) || !push_c);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: directed tables, corner sequences and a
// randomized run against a queue-based model of the FIFO and adapter.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();
  fifo_rd_stream #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [DW-1:0] data;
    int            stamp;
  } ent_t;

  typedef struct {
    logic          ready;
    logic          flush;
    logic          e_rd;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [1:0]    e_level;
  } vec_t;

  logic [DW-1:0] fq[$];
  ent_t          exp_q[$];
  int            cyc, n_pass, n_chk, n_out, n_reads, gaps, last_out;
  logic          s_rd, s_valid;
  logic [DW-1:0] s_data;
  logic [1:0]    s_level;
  logic          p_valid, p_ready, p_flush;
  logic [DW-1:0] p_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic fifo_write(input logic [DW-1:0] w);
    fq.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  // One clock: sample, compare with model, advance FIFO and model across the edge.
  task automatic cycle();
    int            lvl;
    logic          e_rd, e_valid, rd_hit;
    logic [DW-1:0] nxt;
    #3;
    lvl = 0;
    foreach (exp_q[i]) if (exp_q[i].stamp <= cyc - 2) lvl++;
    e_rd    = !bus.flush && (fq.size() != 0) && (exp_q.size() < 3);
    e_valid = (lvl != 0) && !bus.flush;
    s_rd    = bus.fifo_rd_en;
    s_valid = bus.m_valid;
    s_data  = bus.m_data;
    s_level = bus.buf_level;
    chk("rd_en", 32'(s_rd), 32'(e_rd));
    chk("m_valid", 32'(s_valid), 32'(e_valid));
    chk("buf_level", 32'(s_level), 32'(lvl));
    if (e_valid && exp_q.size() != 0) chk("m_data", 32'(s_data), 32'(exp_q[0].data));
    if (p_valid && !p_ready && !p_flush && !bus.flush)
      chk("hold", {23'd0, s_valid, s_data}, {23'd0, 1'b1, p_data});
    if (s_valid && bus.m_ready) begin
      n_out++;
      if (last_out >= 0 && cyc != last_out + 1) gaps++;
      last_out = cyc;
    end
    if (e_valid && bus.m_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (bus.flush) exp_q.delete();
    rd_hit = 1'b0;
    nxt    = bus.fifo_data;
    if (s_rd && fq.size() != 0) begin
      nxt    = fq.pop_front();
      rd_hit = 1'b1;
      exp_q.push_back('{data: nxt, stamp: cyc});
      n_reads++;
    end
    p_valid = s_valid;
    p_ready = bus.m_ready;
    p_flush = bus.flush;
    p_data  = s_data;
    @(posedge clk);
    #1;
    if (rd_hit) bus.fifo_data = nxt;
    bus.fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  task automatic clear_model();
    fq.delete();
    exp_q.delete();
    cyc = 0; n_out = 0; n_reads = 0; gaps = 0; last_out = -1;
    p_valid = 1'b0; p_ready = 1'b0; p_flush = 1'b0; p_data = '0;
  endtask

  task automatic reset_dut();
    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.m_ready    = 1'b0;
    bus.fifo_data  = '0;
    bus.fifo_empty = 1'b0;
    #2;
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_buf_level", 32'(bus.buf_level), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.fifo_empty = 1'b1;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic run_until_out(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (n_out < n && k < budget) begin
      cycle();
      k++;
    end
    chk(name, 32'(n_out), 32'(n));
  endtask

  vec_t          tv[6];
  logic [DW-1:0] w[6];
  int            pulses;

  initial begin
    n_pass = 0;
    n_chk  = 0;
    clear_model();

    // Basic 3-word stream: latency and back-to-back output.
    tv[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tv[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tv[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h24, 2'd1};
    tv[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 2'd1};
    tv[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h09, 2'd1};
    tv[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
    reset_dut();
    fifo_write(8'h24); fifo_write(8'h81); fifo_write(8'h09);
    for (int i = 0; i < 6; i++) begin
      bus.m_ready = tv[i].ready;
      bus.flush   = tv[i].flush;
      cycle();
      chk("t1_rd_en", 32'(s_rd), 32'(tv[i].e_rd));
      chk("t1_m_valid", 32'(s_valid), 32'(tv[i].e_valid));
      chk("t1_buf_level", 32'(s_level), 32'(tv[i].e_level));
      if (tv[i].e_valid) chk("t1_m_data", 32'(s_data), 32'(tv[i].e_data));
    end

    // Back-pressure: exactly 3 reads, then full-rate drain of 8 words.
    reset_dut();
    for (int i = 0; i < 8; i++) fifo_write(8'(8'h30 + i * 7));
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_rd) pulses++;
    end
    chk("t2_rd_pulses", 32'(pulses), 32'd3);
    chk("t2_buf_level", 32'(s_level), 32'd3);
    chk("t2_m_data", 32'(s_data), 32'h30);
    bus.m_ready = 1'b1;
    n_out = 0; gaps = 0; last_out = -1;
    run_until_out(8, 40, "t2_count");
    chk("t2_gaps", 32'(gaps), 32'd0);

    // Concurrent writes at full rate: 40 random words, no bubbles.
    reset_dut();
    bus.m_ready = 1'b1;
    fifo_write(8'($urandom)); fifo_write(8'($urandom));
    begin
      int written, k;
      written = 2; k = 0;
      while (n_out < 40 && k < 200) begin
        if (written < 40) begin
          fifo_write(8'($urandom));
          written++;
        end
        cycle();
        k++;
      end
    end
    chk("t3_count", 32'(n_out), 32'd40);
    chk("t3_gaps", 32'(gaps), 32'd0);

    // Toggling m_ready across a 10-word stream.
    reset_dut();
    for (int i = 0; i < 10; i++) fifo_write(8'(8'hA0 + i));
    begin
      int k;
      k = 0;
      while (n_out < 10 && k < 80) begin
        bus.m_ready = (k % 2 == 0);
        cycle();
        k++;
      end
    end
    chk("t4_count", 32'(n_out), 32'd10);
    chk("t4_reads", 32'(n_reads), 32'd10);

    // Flush with two buffered words and one in flight.
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      w[i] = 8'(8'h51 + i * 3);
      fifo_write(w[i]);
    end
    cycle(); cycle(); cycle();
    chk("t5_prev_rd", 32'(s_rd), 32'd1);
    bus.flush = 1'b1;
    cycle();
    chk("t5_flush_valid", 32'(s_valid), 32'd0);
    chk("t5_flush_rd", 32'(s_rd), 32'd0);
    chk("t5_flush_level", 32'(s_level), 32'd2);
    chk("t5_reads", 32'(n_reads), 32'd3);
    bus.flush = 1'b0;
    cycle();
    chk("t5_post_level", 32'(s_level), 32'd0);
    chk("t5_none_out", 32'(n_out), 32'd0);
    bus.m_ready = 1'b1;
    begin
      int k;
      k = 0;
      while (!s_valid && k < 10) begin
        cycle();
        k++;
      end
    end
    chk("t5_next_word", {23'd0, s_valid, s_data}, {23'd0, 1'b1, w[3]});
    run_until_out(3, 20, "t5_drain");

    // Asynchronous reset mid-stream, then clean restart.
    reset_dut();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 20; i++) fifo_write(8'(8'hC0 + i));
    for (int i = 0; i < 6; i++) cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.m_valid), 32'd0);
    chk("t6_rst_rd", 32'(bus.fifo_rd_en), 32'd0);
    chk("t6_rst_level", 32'(bus.buf_level), 32'd0);
    @(posedge clk);
    #1;
    clear_model();
    bus.fifo_data  = '0;
    bus.fifo_empty = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) fifo_write(8'(8'h11 * (i + 1)));
    run_until_out(5, 30, "t6_restart");

    // Randomized traffic, back-pressure and flushes against the model.
    reset_dut();
    for (int k = 0; k < 400; k++) begin
      if ($urandom % 4 != 0) fifo_write(8'($urandom));
      bus.m_ready = ($urandom % 3 != 0);
      bus.flush   = ($urandom % 20 == 0);
      cycle();
    end
    bus.flush   = 1'b0;
    bus.m_ready = 1'b1;
    begin
      int k;
      k = 0;
      while ((fq.size() != 0 || exp_q.size() != 0) && k < 1000) begin
        cycle();
        k++;
      end
    end
    chk("t7_drained", 32'(fq.size() + exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side adapter placed directly downstream of sync_fifo_ptr. It drives the FIFO's rd_en, absorbs the FIFO's 1-cycle registered read latency, and presents the data as a valid/ready stream. A 3-entry prefetch buffer sustains one word per cycle, and fifo_rd_en has no combinational path from m_ready. A synchronous flush discards buffered and in-flight words.

Parameters:
DATA_WIDTH, 8, word width; must match the upstream FIFO's DATA_WIDTH.
BUF_DEPTH, 3, prefetch buffer entries; localparam, not overridable. 3 is the minimum for full rate without an m_ready→rd_en combinational path.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO data_out; valid the cycle after a read is issued
fifo_rd_en  output  1  FIFO read strobe
flush  input  1  synchronous discard of buffered and in-flight data
m_valid  output  1  output word valid
m_ready  input  1  consumer ready
m_data  output  DATA_WIDTH  output word (buffer head)
buf_level  output  2  buffered word count, 0..3

Behaviour:
- Reset (async assert, sync release): occ=0, inflight=0, rd/wr pointers=0, all buffer entries=0, m_valid=0, m_data=0, buf_level=0, fifo_rd_en=0.
- State: occ (0..3) words held; inflight (1 bit) set when a read was issued last cycle.
- Read issue (combinational on registered state plus fifo_empty only): fifo_rd_en = !rst && !flush && !fifo_empty && (occ + inflight < 3).
- Latency: fifo_rd_en high in cycle t → fifo_data sampled and pushed at the edge ending t+1 → m_valid high in t+2. Empty-to-first-output latency is 2 cycles.
- Push: when inflight=1, fifo_data is written at wr_ptr. No overflow is possible by construction; an assertion checks occ<3 || !push.
- Pop: m_valid && m_ready advances rd_ptr.
- Simultaneous push and pop: occ is unchanged and pointers both advance.
- Pointer wrap: pointers wrap 2→0 (mod 3, not a power of 2); explicit compare, no bit truncation.
- m_valid = (occ != 0). m_data = buf[rd_ptr]. m_data is held stable while m_valid && !m_ready. m_data is don't-care when m_valid=0 but never X after reset.
- Steady state with m_ready=1 and FIFO non-empty: one word per cycle, no bubbles.
- m_ready low: reads stop once occ + inflight reaches 3; nothing is lost.
- FIFO goes empty mid-stream: reads stop, buffer drains, m_valid drops after the last word.
- flush=1 in cycle t: fifo_rd_en=0, m_valid forced 0 (no transfer counted), any in-flight word is discarded, and at the edge occ←0, inflight←0, pointers←0. Words already popped from the FIFO are lost by design. FIFO contents are untouched.
- Reset asserted mid-operation: immediate clear regardless of inflight. The FIFO has its own reset.
- Ordering: output order equals FIFO read order; no duplication, no drop (except on flush).

Decomposition:
- Shared package fifo_pkg: DEFAULT_DATA_WIDTH=8, localparam BUF_DEPTH=3, typedef buf_ptr_t (logic [1:0]), typedef buf_cnt_t (logic [1:0]).
- One sub-module, fifo_rd_stream_buf: 3-entry register file with wr_ptr/rd_ptr/occ and push/pop/clear inputs. The top holds the issue logic, the inflight flag and the flush handling.

Test Plan:
- Reset then load the FIFO with 0x24,0x81,0x09 while m_ready=1 → fifo_rd_en high in 3 consecutive cycles; m_data 0x24,0x81,0x09 on 3 consecutive cycles starting 2 cycles after the first rd_en.
- 8 words preloaded, m_ready=0 → exactly 3 rd_en pulses, buf_level=3, m_data=word0 held. Raise m_ready → all 8 words out back-to-back in order.
- Concurrent FIFO writes and m_ready=1 for 40 random words → scoreboard match, zero output bubbles after the first word, buf_level never exceeds 3.
- m_ready toggled 1,0,1,0 during a 10-word stream → m_data stable whenever valid && !ready, 10 words in order, no duplicates.
- flush asserted one cycle after a rd_en with buf_level=2 → that cycle has m_valid=0 and fifo_rd_en=0; next cycle buf_level=0; the next output is the following FIFO word; 3 words consumed from the FIFO, none emitted.
- rst pulsed asynchronously mid-stream (between edges) → m_valid, fifo_rd_en and buf_level go to 0 immediately; after release and FIFO re-init, the stream restarts cleanly.
